divider_inverse_mul: RTL and testbench



---
 rtl/divider_inverse_mul_pkg.sv | 26 ++
 rtl/divider_inverse_mul_if.sv | 31 +++
 rtl/divider_inverse_mul_mul_step.sv | 27 ++
 rtl/divider_inverse_mul.sv | 102 ++++++++++
 tb/tb_divider_inverse_mul.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/divider_inverse_mul_pkg.sv
// Shared definitions for the divider / inverse-multiplier pair.
//   state_t        : engine state (IDLE, RUN, DONE), also exported for debug
//   WQ_DEF, WB_DEF : default quotient and divisor/remainder widths
//   calc_dividend  : reference reconstruction Q*B+R at the default widths
package divider_pkg;

    localparam int WQ_DEF = 4;
    localparam int WB_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WQ_DEF+WB_DEF-1:0] calc_dividend(
        input logic [WQ_DEF-1:0] q,
        input logic [WB_DEF-1:0] b,
        input logic [WB_DEF-1:0] r
    );
        logic [WQ_DEF+WB_DEF-1:0] prod;
        prod = {{WB_DEF{1'b0}}, q} * {{WQ_DEF{1'b0}}, b};
        return prod + {{WQ_DEF{1'b0}}, r};
    endfunction

endpackage

// File: rtl/divider_inverse_mul_if.sv
// Operand/result bus of the inverse multiplier.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; the producer holds valid and its payload stable until that edge.
//   in_valid/in_ready/q_in/b_in/r_in : operand channel (master -> slave)
//   out_valid/out_ready/p_out/rem_err: result channel  (slave -> master)
interface divider_inverse_mul_if
    import divider_pkg::*;
#(
    parameter int WQ = WQ_DEF,
    parameter int WB = WB_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WQ-1:0]    q_in;
    logic [WB-1:0]    b_in;
    logic [WB-1:0]    r_in;
    logic             out_valid;
    logic             out_ready;
    logic [WQ+WB-1:0] p_out;
    logic             rem_err;

    modport master (
        output in_valid, q_in, b_in, r_in, out_ready,
        input  in_ready, out_valid, p_out, rem_err
    );

    modport slave (
        input  in_valid, q_in, b_in, r_in, out_ready,
        output in_ready, out_valid, p_out, rem_err
    );
endinterface

// File: rtl/divider_inverse_mul_mul_step.sv
// One shift-and-add iteration: acc_next = acc + (q << shift) when add_en.
//   acc      : running accumulator (WQ+WB bits)
//   q        : quotient operand
//   add_en   : divisor bit selected for this iteration
//   shift    : iteration index, i.e. weight of that divisor bit
//   acc_next : accumulator after this iteration
module mul_step
    import divider_pkg::*;
#(
    parameter int WQ = WQ_DEF,
    parameter int WB = WB_DEF,
    parameter int CW = 1
) (
    input  logic [WQ+WB-1:0] acc,
    input  logic [WQ-1:0]    q,
    input  logic             add_en,
    input  logic [CW-1:0]    shift,
    output logic [WQ+WB-1:0] acc_next
);
    logic [WQ+WB-1:0] q_ext;
    logic [WQ+WB-1:0] partial;

    assign q_ext    = {{WB{1'b0}}, q};
    assign partial  = q_ext << shift;
    // Width WQ+WB cannot overflow: Q*B+R <= (2^WQ-1)(2^WB-1)+2^WB-1 < 2^(WQ+WB).
    assign acc_next = add_en ? (acc + partial) : acc;
endmodule

// File: rtl/divider_inverse_mul.sv
// Sequential reconstructor P = Q*B + R, the round-trip partner of the 4-by-2
// divider. Accepts one operand set in IDLE, spends exactly WB RUN cycles
// adding shifted copies of Q for each set bit of B, then holds the result in
// DONE until the consumer takes it. rem_err flags R >= B (always when B == 0)
// but does not suppress the result.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand/result handshake bus (slave side)
//   state_dbg  : current engine state
module divider_inverse_mul
    import divider_pkg::*;
#(
    parameter int WQ = WQ_DEF,
    parameter int WB = WB_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    divider_inverse_mul_if.slave   bus,
    output state_t                 state_dbg
);
    localparam int W  = WQ + WB;
    localparam int CW = (WB > 1) ? $clog2(WB) : 1;

    state_t        state_q;
    state_t        state_d;
    logic [WQ-1:0] q_reg;
    logic [WB-1:0] b_reg;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic [CW-1:0] cnt;
    logic          err_reg;
    logic          accept;
    logic          last_iter;

    // in_valid only counts in IDLE; out_ready only counts in DONE.
    assign accept    = bus.in_valid && (state_q == IDLE);
    assign last_iter = (cnt == CW'(WB - 1));

    mul_step #(
        .WQ (WQ),
        .WB (WB),
        .CW (CW)
    ) u_step (
        .acc      (acc),
        .q        (q_reg),
        .add_en   (b_reg[cnt]),
        .shift    (cnt),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)        state_d = RUN;
            RUN:  if (last_iter)     state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            err_reg <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        q_reg   <= bus.q_in;
                        b_reg   <= bus.b_in;
                        acc     <= {{WQ{1'b0}}, bus.r_in};
                        cnt     <= '0;
                        err_reg <= (bus.r_in >= bus.b_in);
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= last_iter ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result pins are forced to zero outside DONE so a partial accumulator
    // is never visible.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.p_out     = (state_q == DONE) ? acc : '0;
    assign bus.rem_err   = (state_q == DONE) && err_reg;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_divider_inverse_mul.sv
module tb_divider_inverse_mul;
    import divider_pkg::*;

    localparam int WQ = 4;
    localparam int WB = 2;
    localparam int W  = WQ + WB;

    logic   clk;
    logic   rst_n;
    state_t state_dbg;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {rem_err, p_out}
    logic [W:0] exp_q[$];

    divider_inverse_mul_if #(.WQ(WQ), .WB(WB)) bus ();

    divider_inverse_mul #(.WQ(WQ), .WB(WB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: present operands, wait (bounded) for acceptance, push expectation
    task automatic send(input logic [WQ-1:0] q, input logic [WB-1:0] b,
                        input logic [WB-1:0] r, input bit push);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.in_ready !== 1'b1) check("send_timeout", 32'(bus.in_ready), 32'd1);
        bus.q_in     = q;
        bus.b_in     = b;
        bus.r_in     = r;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.q_in     = 4'($urandom_range(0, 15));
        bus.b_in     = 2'($urandom_range(0, 3));
        bus.r_in     = 2'($urandom_range(0, 3));
        if (push) exp_q.push_back({(r >= b), calc_dividend(q, b, r)});
    endtask

    // monitor: wait (bounded) for a result, compare against scoreboard head
    task automatic collect(input string tag);
        int n;
        logic [W:0] e;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.out_valid !== 1'b1) begin
            check({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_p"},   32'(bus.p_out),   32'(e[W-1:0]));
            check({tag, "_err"}, 32'(bus.rem_err), 32'(e[W]));
        end
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.q_in      = '0;
        bus.b_in      = '0;
        bus.r_in      = '0;
        bus.out_ready = 1'b1;

        // reset state
        repeat (3) tick();
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_p_out",     32'(bus.p_out),     32'd0);
        check("rst_rem_err",   32'(bus.rem_err),   32'd0);
        check("rst_state",     32'(state_dbg),     32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // first transaction with explicit latency checks: 11*3+2 = 35
        send(4'd11, 2'd3, 2'd2, 1'b1);
        check("lat_in_ready_busy", 32'(bus.in_ready),  32'd0);
        check("lat_edge0_valid",   32'(bus.out_valid), 32'd0);
        tick();
        check("lat_edge1_valid",   32'(bus.out_valid), 32'd0);
        tick();
        check("lat_edge2_valid",   32'(bus.out_valid), 32'd1);
        check("lat_done_ready",    32'(bus.in_ready),  32'd0);
        check("t1_p_literal",      32'(bus.p_out),     32'd35);
        collect("t1");
        check("t1_in_ready_back",  32'(bus.in_ready),  32'd1);
        check("t1_out_valid_drop", 32'(bus.out_valid), 32'd0);

        // directed cases
        send(4'd15, 2'd3, 2'd2, 1'b1);
        collect("max_ok");
        send(4'd9, 2'd0, 2'd0, 1'b1);
        collect("b_zero");
        send(4'd5, 2'd2, 2'd3, 1'b1);
        collect("r_ge_b");
        send(4'd0, 2'd1, 2'd0, 1'b1);
        collect("zero_q");
        send(4'd15, 2'd3, 2'd3, 1'b1);
        collect("all_ones");

        // random operands
        for (int i = 0; i < 8; i++) begin
            send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 1'b1);
            collect("rand");
        end

        // backpressure with stray in_valid pulses: 6*1+0 = 6
        bus.out_ready = 1'b0;
        send(4'd6, 2'd1, 2'd0, 1'b1);
        bus.q_in     = 4'd15;
        bus.b_in     = 2'd3;
        bus.r_in     = 2'd3;
        bus.in_valid = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 32'(bus.out_valid), 32'd1);
            check("bp_p_held",     32'(bus.p_out),     32'd6);
            check("bp_no_accept",  32'(bus.in_ready),  32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        collect("bp");
        bus.in_valid = 1'b0;
        check("bp_idle_after", 32'(state_dbg), 32'(IDLE));
        for (int i = 0; i < 4; i++) begin
            check("bp_no_ghost", 32'(bus.out_valid), 32'd0);
            tick();
        end

        // reset mid-RUN discards the transaction
        send(4'd7, 2'd3, 2'd1, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_p_out",     32'(bus.p_out),     32'd0);
        check("mrst_rem_err",   32'(bus.rem_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(4'd2, 2'd2, 2'd1, 1'b1);
        collect("post_rst");
        check("post_rst_p_literal_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
